// File: rtl/reg_writeback_arbiter.sv
// Sole driver of the register-file write port: merges the ALU stream with buffered
// long-latency results and tracks registers still waiting on a long-latency writeback.
module reg_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_we_i,
    input  logic [4:0]                 alu_addr_i,
    input  logic [31:0]                alu_data_i,
    input  logic                       lu_valid_i,
    output logic                       lu_ready_o,
    input  logic [4:0]                 lu_addr_i,
    input  logic [31:0]                lu_data_i,
    input  logic                       issue_i,
    input  logic [4:0]                 issue_addr_i,
    output logic                       RegWrite_o,
    output logic [4:0]                 RDaddr_o,
    output logic [31:0]                RDdata_o,
    output logic [31:0]                pending_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX_C = SW'(STARVE_MAX);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          stall_q, err_q, we_q;
    logic [4:0]    addr_q;
    logic [31:0]   data_q;

    logic          alu_sel, fifo_empty, push, pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    // An ALU write aimed at r0 is a no-op, so it must not steal the port from the FIFO.
    assign alu_sel    = alu_we_i & (alu_addr_i != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign pop        = ~alu_sel & ~fifo_empty;
    assign lu_ready_o = (count_q < FULL_C) & ~rst_i;
    assign push       = lu_valid_i & lu_ready_o & (lu_addr_i != 5'd0);
    assign head_addr  = fifo_addr[rd_ptr_q];
    assign head_data  = fifo_data[rd_ptr_q];

    // NOTE: every variable gets a default first, so no path through always_comb infers a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SMAX_C) begin
            starve_d = starve_q + SW'(1);
        end

        // Clear before set so a same-cycle issue to the popped register stays pending.
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_addr] = 1'b0;
        end
        if (issue_i) begin
            pending_d[issue_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update off the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (alu_sel) begin
                we_q   <= 1'b1;
                addr_q <= alu_addr_i;
                data_q <= alu_data_i;
            end else if (pop) begin
                we_q   <= 1'b1;
                addr_q <= head_addr;
                data_q <= head_data;
            end else begin
                we_q   <= 1'b0;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            stall_q   <= (starve_d == SMAX_C);
            if (alu_we_i && stall_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= lu_addr_i;
            fifo_data[wr_ptr_q] <= lu_data_i;
        end
    end

    assign RegWrite_o = we_q;
    assign RDaddr_o   = addr_q;
    assign RDdata_o   = data_q;
    assign pending_o  = pending_q;
    assign stall_o    = stall_q;
    assign count_o    = count_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: a vector table for the write-port and FIFO paths,
// then hand sequences for starvation, the scoreboard set/clear race and asynchronous reset.
module tb_reg_writeback_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_we_i, lu_valid_i, issue_i;
    logic [4:0]  alu_addr_i, lu_addr_i, issue_addr_i;
    logic [31:0] alu_data_i, lu_data_i;
    logic        lu_ready_o, RegWrite_o, stall_o, err_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o, pending_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_we_i(alu_we_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
        .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
        .issue_i(issue_i), .issue_addr_i(issue_addr_i),
        .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .pending_o(pending_o), .stall_o(stall_o), .count_o(count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        alu_we;
        logic [4:0]  alu_addr;
        logic [31:0] alu_data;
        logic        lu_valid;
        logic [4:0]  lu_addr;
        logic [31:0] lu_data;
        logic        issue;
        logic [4:0]  issue_addr;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [2:0]  exp_count;
        logic        exp_ready;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(
        input logic aw, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic is, input logic [4:0] ia,
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic [2:0] ec, input logic er, input logic [31:0] ep);
        vec_t v;
        v.alu_we = aw; v.alu_addr = aa; v.alu_data = ad;
        v.lu_valid = lv; v.lu_addr = la; v.lu_data = ld;
        v.issue = is; v.issue_addr = ia;
        v.exp_we = ew; v.exp_addr = ea; v.exp_data = ed;
        v.exp_count = ec; v.exp_ready = er; v.exp_pend = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic drive(
        input logic aw, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic is, input logic [4:0] ia);
        alu_we_i = aw; alu_addr_i = aa; alu_data_i = ad;
        lu_valid_i = lv; lu_addr_i = la; lu_data_i = ld;
        issue_i = is; issue_addr_i = ia;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        // ---- vectors: ALU path, r0 filtering, priority/drain order, full + wrap ----
        tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,   1, 5'd8,  1, 5'd5,  32'hDEADBEEF, 3'd0, 1, 32'h0000_0100);
        tbl[1]  = mk(1, 5'd0, 32'h11111111, 0, 5'd0,  32'h0,   1, 5'd9,  0, 5'd5,  32'hDEADBEEF, 3'd0, 1, 32'h0000_0300);
        tbl[2]  = mk(0, 5'd0, 32'h0,        1, 5'd0,  32'h22,  1, 5'd10, 0, 5'd5,  32'hDEADBEEF, 3'd0, 1, 32'h0000_0700);
        tbl[3]  = mk(1, 5'd1, 32'h100,      1, 5'd8,  32'h800, 0, 5'd0,  1, 5'd1,  32'h100,      3'd1, 1, 32'h0000_0700);
        tbl[4]  = mk(1, 5'd2, 32'h200,      1, 5'd9,  32'h900, 0, 5'd0,  1, 5'd2,  32'h200,      3'd2, 1, 32'h0000_0700);
        tbl[5]  = mk(1, 5'd3, 32'h300,      1, 5'd10, 32'hA00, 0, 5'd0,  1, 5'd3,  32'h300,      3'd3, 1, 32'h0000_0700);
        tbl[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd8,  32'h800,      3'd2, 1, 32'h0000_0600);
        tbl[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd9,  32'h900,      3'd1, 1, 32'h0000_0400);
        tbl[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd10, 32'hA00,      3'd0, 1, 32'h0000_0000);
        tbl[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  0, 5'd10, 32'hA00,      3'd0, 1, 32'h0000_0000);
        tbl[10] = mk(1, 5'd1, 32'h1,        1, 5'd16, 32'hA16, 0, 5'd0,  1, 5'd1,  32'h1,        3'd1, 1, 32'h0);
        tbl[11] = mk(1, 5'd2, 32'h2,        1, 5'd17, 32'hA17, 0, 5'd0,  1, 5'd2,  32'h2,        3'd2, 1, 32'h0);
        tbl[12] = mk(1, 5'd3, 32'h3,        1, 5'd18, 32'hA18, 0, 5'd0,  1, 5'd3,  32'h3,        3'd3, 1, 32'h0);
        tbl[13] = mk(1, 5'd4, 32'h4,        1, 5'd19, 32'hA19, 0, 5'd0,  1, 5'd4,  32'h4,        3'd4, 0, 32'h0);
        tbl[14] = mk(1, 5'd5, 32'h5,        1, 5'd20, 32'hA20, 0, 5'd0,  1, 5'd5,  32'h5,        3'd4, 0, 32'h0);
        tbl[15] = mk(0, 5'd0, 32'h0,        1, 5'd20, 32'hA20, 0, 5'd0,  1, 5'd16, 32'hA16,      3'd3, 1, 32'h0);
        tbl[16] = mk(1, 5'd6, 32'h6,        1, 5'd20, 32'hA20, 0, 5'd0,  1, 5'd6,  32'h6,        3'd4, 0, 32'h0);
        tbl[17] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd17, 32'hA17,      3'd3, 1, 32'h0);
        tbl[18] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd18, 32'hA18,      3'd2, 1, 32'h0);
        tbl[19] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd19, 32'hA19,      3'd1, 1, 32'h0);
        tbl[20] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  1, 5'd20, 32'hA20,      3'd0, 1, 32'h0);
        tbl[21] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,   0, 5'd0,  0, 5'd20, 32'hA20,      3'd0, 1, 32'h0);

        rst_i = 1'b1;
        alu_we_i = 1'b0; alu_addr_i = 5'd0; alu_data_i = 32'h0;
        lu_valid_i = 1'b0; lu_addr_i = 5'd0; lu_data_i = 32'h0;
        issue_i = 1'b0; issue_addr_i = 5'd0;

        @(negedge clk_i);
        check("rst.we",      {31'h0, RegWrite_o}, 32'h0);
        check("rst.addr",    {27'h0, RDaddr_o},   32'h0);
        check("rst.data",    RDdata_o,            32'h0);
        check("rst.count",   {29'h0, count_o},    32'h0);
        check("rst.pending", pending_o,           32'h0);
        check("rst.stall",   {31'h0, stall_o},    32'h0);
        check("rst.err",     {31'h0, err_o},      32'h0);
        check("rst.ready",   {31'h0, lu_ready_o}, 32'h0);
        rst_i = 1'b0;
        #1;
        check("rel.ready",   {31'h0, lu_ready_o}, 32'h1);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].alu_we, tbl[i].alu_addr, tbl[i].alu_data,
                  tbl[i].lu_valid, tbl[i].lu_addr, tbl[i].lu_data,
                  tbl[i].issue, tbl[i].issue_addr);
            check($sformatf("v%0d.we", i),      {31'h0, RegWrite_o}, {31'h0, tbl[i].exp_we});
            check($sformatf("v%0d.addr", i),    {27'h0, RDaddr_o},   {27'h0, tbl[i].exp_addr});
            check($sformatf("v%0d.data", i),    RDdata_o,            tbl[i].exp_data);
            check($sformatf("v%0d.count", i),   {29'h0, count_o},    {29'h0, tbl[i].exp_count});
            check($sformatf("v%0d.ready", i),   {31'h0, lu_ready_o}, {31'h0, tbl[i].exp_ready});
            check($sformatf("v%0d.pending", i), pending_o,           tbl[i].exp_pend);
            check($sformatf("v%0d.stall", i),   {31'h0, stall_o},    32'h0);
        end

        // ---- starvation: one queued result, ALU busy until stall, then contract violation ----
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        check("starve.count", {29'h0, count_o}, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 5'd2, 32'(k), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        end
        check("starve.stall7", {31'h0, stall_o}, 32'h0);
        drive(1'b1, 5'd2, 32'h8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("starve.stall8", {31'h0, stall_o}, 32'h1);
        check("starve.err8",   {31'h0, err_o},   32'h0);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("viol.addr",  {27'h0, RDaddr_o}, 32'd3);
        check("viol.err",   {31'h0, err_o},    32'h1);
        check("viol.stall", {31'h0, stall_o},  32'h1);
        check("viol.count", {29'h0, count_o},  32'h1);
        idle();
        check("drain.addr",  {27'h0, RDaddr_o}, 32'd7);
        check("drain.data",  RDdata_o,          32'h77);
        check("drain.stall", {31'h0, stall_o},  32'h0);
        check("drain.err",   {31'h0, err_o},    32'h1);
        idle();
        check("after.we",  {31'h0, RegWrite_o}, 32'h0);
        check("after.err", {31'h0, err_o},      32'h1);

        // ---- scoreboard: re-issue of r12 in its pop cycle keeps it pending ----
        drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        check("race.pend0", pending_o, 32'h0000_1000);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0);
        check("race.count", {29'h0, count_o}, 32'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        check("race.addr",  {27'h0, RDaddr_o}, 32'd12);
        check("race.data",  RDdata_o,          32'hC0C0);
        check("race.pend1", pending_o,         32'h0000_1000);
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13);
        check("race.pend2", pending_o, 32'h0000_3000);
        idle();
        check("clear.addr", {27'h0, RDaddr_o}, 32'd12);
        check("clear.pend", pending_o,         32'h0000_2000);

        // ---- asynchronous reset with two entries queued ----
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd21, 32'h21, 1'b1, 5'd14);
        check("pre.count", {29'h0, count_o}, 32'h2);
        check("pre.pend",  pending_o,        32'h0000_6000);
        alu_we_i = 1'b0; lu_valid_i = 1'b0; issue_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("arst.we",      {31'h0, RegWrite_o}, 32'h0);
        check("arst.addr",    {27'h0, RDaddr_o},   32'h0);
        check("arst.data",    RDdata_o,            32'h0);
        check("arst.count",   {29'h0, count_o},    32'h0);
        check("arst.pending", pending_o,           32'h0);
        check("arst.stall",   {31'h0, stall_o},    32'h0);
        check("arst.err",     {31'h0, err_o},      32'h0);
        check("arst.ready",   {31'h0, lu_ready_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("arel.ready", {31'h0, lu_ready_o}, 32'h1);
        idle();
        check("arel.we",    {31'h0, RegWrite_o}, 32'h0);
        check("arel.count", {29'h0, count_o},    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
